// File: rtl/security_zone_ctrl.sv
// security_zone_ctrl
// Intrusion-alarm controller: arm with exit delay, per-zone instant or
// entry-delay sensors, timed alarm followed by lockout, trip latching and
// a saturating count of alarm events. Every output comes straight from a flop.
module security_zone_ctrl #(
    parameter int NUM_ZONES   = 4,
    parameter int CNT_W       = 8,
    parameter int EXIT_DELAY  = 8,
    parameter int ENTRY_DELAY = 8,
    parameter int ALARM_TIME  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic [NUM_ZONES-1:0] zone_in,
    input  logic [NUM_ZONES-1:0] zone_en,
    input  logic [NUM_ZONES-1:0] zone_delayed,
    output logic [2:0]           state,
    output logic                 alarm,
    output logic [NUM_ZONES-1:0] tripped,
    output logic [3:0]           alarm_cnt
);

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4,
        LOCKOUT  = 3'd5
    } state_t;

    // Counter reload values; each delay lasts exactly N cycles, so N-1 is loaded
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t                 state_r;
    state_t                 state_nxt_s;
    state_t                 fsm_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [CNT_W-1:0]       cnt_fsm_s;
    logic [NUM_ZONES-1:0]   tripped_r;
    logic [NUM_ZONES-1:0]   tripped_nxt_s;
    logic                   alarm_r;
    logic [3:0]             alarm_cnt_r;
    logic                   force_disarm_s;
    logic                   enter_alarm_s;

    logic [NUM_ZONES-1:0]   act_s;
    logic [NUM_ZONES-1:0]   inst_s;
    logic [NUM_ZONES-1:0]   dly_s;

    assign act_s  = zone_in & zone_en;
    assign inst_s = act_s & ~zone_delayed;
    assign dly_s  = act_s & zone_delayed;

    // Disarm overrides everything once the system has left DISARMED
    assign force_disarm_s = disarm && (state_r != DISARMED);

    // Next-state, counter and trip-latch logic for the alarm sequencer
    always_comb begin
        fsm_nxt_s     = state_r;
        cnt_fsm_s     = cnt_r;
        tripped_nxt_s = tripped_r;
        case (state_r)
            DISARMED: begin
                if (arm && !disarm) begin
                    fsm_nxt_s     = EXIT;
                    cnt_fsm_s     = EXIT_LOAD;
                    tripped_nxt_s = {NUM_ZONES{1'b0}};
                end else begin
                    fsm_nxt_s = DISARMED;
                end
            end
            EXIT: begin
                // Sensors are deliberately ignored while the occupant leaves
                if (cnt_r == CNT_ZERO) begin
                    fsm_nxt_s = ARMED;
                end else begin
                    cnt_fsm_s = cnt_r - CNT_ONE;
                end
            end
            ARMED: begin
                tripped_nxt_s = tripped_r | act_s;
                if (inst_s != {NUM_ZONES{1'b0}}) begin
                    fsm_nxt_s = ALARM;
                    cnt_fsm_s = ALARM_LOAD;
                end else if (dly_s != {NUM_ZONES{1'b0}}) begin
                    fsm_nxt_s = ENTRY;
                    cnt_fsm_s = ENTRY_LOAD;
                end else begin
                    fsm_nxt_s = ARMED;
                end
            end
            ENTRY: begin
                tripped_nxt_s = tripped_r | act_s;
                if (inst_s != {NUM_ZONES{1'b0}}) begin
                    fsm_nxt_s = ALARM;
                    cnt_fsm_s = ALARM_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    fsm_nxt_s = ALARM;
                    cnt_fsm_s = ALARM_LOAD;
                end else begin
                    cnt_fsm_s = cnt_r - CNT_ONE;
                end
            end
            ALARM: begin
                tripped_nxt_s = tripped_r | act_s;
                if (cnt_r == CNT_ZERO) begin
                    fsm_nxt_s = LOCKOUT;
                end else begin
                    cnt_fsm_s = cnt_r - CNT_ONE;
                end
            end
            LOCKOUT: begin
                fsm_nxt_s = LOCKOUT;
            end
            default: begin
                // Unused encodings recover to the safe state
                fsm_nxt_s = DISARMED;
            end
        endcase

        if (force_disarm_s) begin
            state_nxt_s = DISARMED;
            cnt_nxt_s   = cnt_r;
        end else begin
            state_nxt_s = fsm_nxt_s;
            cnt_nxt_s   = cnt_fsm_s;
        end

        enter_alarm_s = (state_nxt_s == ALARM) && (state_r != ALARM);
    end

    // State and delay-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DISARMED;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered alarm flag, trip latch and saturating alarm-event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_r     <= 1'b0;
            tripped_r   <= {NUM_ZONES{1'b0}};
            alarm_cnt_r <= 4'd0;
        end else begin
            alarm_r   <= (state_nxt_s == ALARM);
            tripped_r <= tripped_nxt_s;
            if (enter_alarm_s && (alarm_cnt_r != 4'd15)) begin
                alarm_cnt_r <= alarm_cnt_r + 4'd1;
            end else begin
                alarm_cnt_r <= alarm_cnt_r;
            end
        end
    end

    assign state     = state_r;
    assign alarm     = alarm_r;
    assign tripped   = tripped_r;
    assign alarm_cnt = alarm_cnt_r;

endmodule

// File: tb/tb_security_zone_ctrl.sv
// tb_security_zone_ctrl
// Directed, table-driven bench for security_zone_ctrl at default parameters,
// with hand-written sequences for counter saturation and asynchronous reset.
module tb_security_zone_ctrl;

    localparam logic [2:0] S_DIS  = 3'd0;
    localparam logic [2:0] S_EXIT = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_ENT  = 3'd3;
    localparam logic [2:0] S_ALM  = 3'd4;
    localparam logic [2:0] S_LOCK = 3'd5;

    logic       clk;
    logic       rst_n;
    logic       arm;
    logic       disarm;
    logic [3:0] zone_in;
    logic [3:0] zone_en;
    logic [3:0] zone_delayed;
    logic [2:0] state;
    logic       alarm;
    logic [3:0] tripped;
    logic [3:0] alarm_cnt;

    int total_checks;
    int passed_checks;

    typedef struct packed {
        logic [7:0] cyc;
        logic       arm;
        logic       dis;
        logic [3:0] zin;
        logic [3:0] zen;
        logic [2:0] st;
        logic       al;
        logic [3:0] tr;
        logic [3:0] ac;
    } vec_t;

    vec_t vq[$];

    security_zone_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .disarm       (disarm),
        .zone_in      (zone_in),
        .zone_en      (zone_en),
        .zone_delayed (zone_delayed),
        .state        (state),
        .alarm        (alarm),
        .tripped      (tripped),
        .alarm_cnt    (alarm_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_checks = total_checks + 1;
        if (got === exp) begin
            passed_checks = passed_checks + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic al,
                             input logic [3:0] tr, input logic [3:0] ac);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".alarm"}, 32'(alarm), 32'(al));
        check({tag, ".tripped"}, 32'(tripped), 32'(tr));
        check({tag, ".alarm_cnt"}, 32'(alarm_cnt), 32'(ac));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input int cyc, input logic a, input logic d, input logic [3:0] zi,
                       input logic [3:0] ze, input logic [2:0] st, input logic al,
                       input logic [3:0] tr, input logic [3:0] ac);
        vec_t v;
        v.cyc = 8'(cyc); v.arm = a; v.dis = d; v.zin = zi; v.zen = ze;
        v.st = st; v.al = al; v.tr = tr; v.ac = ac;
        vq.push_back(v);
    endtask

    initial begin
        int exp_cnt;
        total_checks  = 0;
        passed_checks = 0;
        rst_n = 1'b0; arm = 1'b0; disarm = 1'b0;
        zone_in = 4'h0; zone_en = 4'hF; zone_delayed = 4'h1;

        // cyc arm dis zin  zen    state  alarm tripped cnt
        add(1, 1'b0, 1'b0, 4'h0, 4'hF, S_DIS,  1'b0, 4'h0, 4'd0);  // idle after reset
        add(1, 1'b1, 1'b0, 4'h0, 4'hF, S_EXIT, 1'b0, 4'h0, 4'd0);  // arm pulse
        add(6, 1'b0, 1'b0, 4'h0, 4'hF, S_EXIT, 1'b0, 4'h0, 4'd0);  // exit running
        add(1, 1'b0, 1'b0, 4'hF, 4'hF, S_EXIT, 1'b0, 4'h0, 4'd0);  // 8th exit cycle, zones ignored
        add(1, 1'b0, 1'b0, 4'h0, 4'hF, S_ARM,  1'b0, 4'h0, 4'd0);  // armed on 9th cycle
        add(3, 1'b0, 1'b0, 4'h8, 4'h7, S_ARM,  1'b0, 4'h0, 4'd0);  // disabled zone ignored
        add(1, 1'b0, 1'b0, 4'h1, 4'hF, S_ENT,  1'b0, 4'h1, 4'd0);  // delayed zone -> entry
        add(7, 1'b0, 1'b0, 4'h0, 4'hF, S_ENT,  1'b0, 4'h1, 4'd0);  // 8th entry cycle
        add(1, 1'b0, 1'b0, 4'h0, 4'hF, S_ALM,  1'b1, 4'h1, 4'd1);  // entry expires
        add(15, 1'b0, 1'b0, 4'h0, 4'hF, S_ALM, 1'b1, 4'h1, 4'd1);  // 16th alarm cycle
        add(1, 1'b0, 1'b0, 4'h0, 4'hF, S_LOCK, 1'b0, 4'h1, 4'd1);  // lockout
        add(2, 1'b1, 1'b0, 4'h0, 4'hF, S_LOCK, 1'b0, 4'h1, 4'd1);  // arm ignored in lockout
        add(1, 1'b1, 1'b1, 4'h0, 4'hF, S_DIS,  1'b0, 4'h1, 4'd1);  // disarm wins over arm
        add(1, 1'b1, 1'b0, 4'h0, 4'hF, S_EXIT, 1'b0, 4'h0, 4'd1);  // re-arm clears tripped
        add(8, 1'b0, 1'b0, 4'h0, 4'hF, S_ARM,  1'b0, 4'h0, 4'd1);
        add(1, 1'b0, 1'b0, 4'h1, 4'hF, S_ENT,  1'b0, 4'h1, 4'd1);
        add(3, 1'b0, 1'b0, 4'h0, 4'hF, S_ENT,  1'b0, 4'h1, 4'd1);
        add(1, 1'b0, 1'b0, 4'h4, 4'hF, S_ALM,  1'b1, 4'h5, 4'd2);  // instant zone mid-entry
        add(1, 1'b1, 1'b1, 4'h0, 4'hF, S_DIS,  1'b0, 4'h5, 4'd2);  // arm+disarm in alarm
        add(1, 1'b0, 1'b0, 4'h0, 4'hF, S_DIS,  1'b0, 4'h5, 4'd2);  // tripped held
        add(1, 1'b1, 1'b0, 4'h0, 4'hF, S_EXIT, 1'b0, 4'h0, 4'd2);
        add(8, 1'b0, 1'b0, 4'h0, 4'hF, S_ARM,  1'b0, 4'h0, 4'd2);
        add(1, 1'b0, 1'b0, 4'h3, 4'hF, S_ALM,  1'b1, 4'h3, 4'd3);  // instant beats delayed
        add(1, 1'b0, 1'b1, 4'h0, 4'hF, S_DIS,  1'b0, 4'h3, 4'd3);
        add(1, 1'b1, 1'b1, 4'h0, 4'hF, S_DIS,  1'b0, 4'h3, 4'd3);  // disarm blocks arm
        add(1, 1'b1, 1'b0, 4'h0, 4'hF, S_EXIT, 1'b0, 4'h0, 4'd3);
        add(1, 1'b1, 1'b1, 4'h0, 4'hF, S_DIS,  1'b0, 4'h0, 4'd3);  // arm held through disarm
        add(1, 1'b1, 1'b0, 4'h0, 4'hF, S_EXIT, 1'b0, 4'h0, 4'd3);  // re-arms after 1 cycle
        add(1, 1'b0, 1'b1, 4'h0, 4'hF, S_DIS,  1'b0, 4'h0, 4'd3);

        // Reset state
        step(2);
        check_all("reset", S_DIS, 1'b0, 4'h0, 4'd0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            arm = vq[i].arm; disarm = vq[i].dis;
            zone_in = vq[i].zin; zone_en = vq[i].zen; zone_delayed = 4'h1;
            step(int'(vq[i].cyc));
            check_all($sformatf("vec%0d", i), vq[i].st, vq[i].al, vq[i].tr, vq[i].ac);
        end
        arm = 1'b0; disarm = 1'b0; zone_in = 4'h0; zone_en = 4'hF;

        // Alarm counter saturation: 14 more alarm entries on top of 3
        exp_cnt = 3;
        for (int k = 0; k < 14; k++) begin
            arm = 1'b1; step(1);
            arm = 1'b0; step(8);
            zone_in = 4'h2; step(1);
            zone_in = 4'h0;
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            check($sformatf("sat%0d.state", k), 32'(state), 32'(S_ALM));
            check($sformatf("sat%0d.alarm_cnt", k), 32'(alarm_cnt), 32'(exp_cnt));
            disarm = 1'b1; step(1);
            disarm = 1'b0;
        end
        check_all("sat_end", S_DIS, 1'b0, 4'h2, 4'd15);

        // Reset in the middle of ALARM clears everything at once
        arm = 1'b1; step(1);
        arm = 1'b0; step(8);
        zone_in = 4'h1; step(1);
        zone_in = 4'h4; step(1);
        zone_in = 4'h0; step(3);
        check_all("pre_rst", S_ALM, 1'b1, 4'h5, 4'd15);
        rst_n = 1'b0; #1;
        check_all("rst_alarm", S_DIS, 1'b0, 4'h0, 4'd0);
        step(1);
        check_all("rst_hold", S_DIS, 1'b0, 4'h0, 4'd0);
        rst_n = 1'b1; arm = 1'b1;
        step(1);
        check_all("post_rst_arm", S_EXIT, 1'b0, 4'h0, 4'd0);

        // Reset in the middle of EXIT, then the block waits for arm
        arm = 1'b0; step(3);
        rst_n = 1'b0; #1;
        check_all("rst_exit", S_DIS, 1'b0, 4'h0, 4'd0);
        rst_n = 1'b1;
        step(10);
        check_all("post_rst_idle", S_DIS, 1'b0, 4'h0, 4'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/security_zone_ctrl.md
SECURITY_ZONE_CTRL -- requirements
Module: security_zone_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ZONES, default 4, number of sensor zones (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, delay counter width.
REQ-003 The block SHALL have parameter EXIT_DELAY, default 8, cycles spent in EXIT (1..2^CNT_W).
REQ-004 The block SHALL have parameter ENTRY_DELAY, default 8, cycles spent in ENTRY (1..2^CNT_W).
REQ-005 The block SHALL have parameter ALARM_TIME, default 16, cycles alarm sounds before LOCKOUT (1..2^CNT_W).
REQ-006 The block SHALL have port clk, input, 1, clock; all state changes on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 The block SHALL have port arm, input, 1, arm request, level sampled per cycle.
REQ-009 The block SHALL have port disarm, input, 1, disarm request, level sampled per cycle.
REQ-010 The block SHALL have port zone_in, input, NUM_ZONES, sensor active-high per zone.
REQ-011 The block SHALL have port zone_en, input, NUM_ZONES, zone enable; disabled zones are ignored.
REQ-012 The block SHALL have port zone_delayed, input, NUM_ZONES, 1 = entry-delay zone, 0 = instant zone.
REQ-013 The block SHALL have port state, output, 3, registered current state encoding.
REQ-014 The block SHALL have port alarm, output, 1, registered, high exactly while state = ALARM.
REQ-015 The block SHALL have port tripped, output, NUM_ZONES, registered latch of zones that caused a trip.
REQ-016 The block SHALL have port alarm_cnt, output, 4, registered count of ALARM entries, saturating at 15.

Function
REQ-017 States SHALL be DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4, LOCKOUT=5; codes 6,7 -> DISARMED next cycle.
REQ-018 Active zones SHALL be act = zone_in & zone_en; inst = act & ~zone_delayed; dly = act & zone_delayed.
REQ-019 disarm=1 in any state other than DISARMED SHALL force DISARMED next cycle; disarm has priority over every other event including arm.
REQ-020 DISARMED: arm=1 and disarm=0 SHALL go to EXIT, load counter with EXIT_DELAY-1, clear tripped.
REQ-021 EXIT: zones SHALL be ignored; counter decrements each cycle; at counter=0 go to ARMED (EXIT lasts exactly EXIT_DELAY cycles).
REQ-022 ARMED: inst!=0 SHALL go to ALARM (load ALARM_TIME-1); else dly!=0 SHALL go to ENTRY (load ENTRY_DELAY-1); inst has priority.
REQ-023 ENTRY: inst!=0 SHALL go to ALARM immediately; else counter decrements and at counter=0 goes to ALARM (load ALARM_TIME-1).
REQ-024 ALARM: counter decrements; at 0 SHALL go to LOCKOUT; zones continue to OR into tripped.
REQ-025 LOCKOUT: SHALL hold until disarm; arm ignored; alarm=0.
REQ-026 tripped SHALL OR in act on every cycle in ARMED, ENTRY or ALARM; held otherwise; cleared only by reset or DISARMED->EXIT.
REQ-027 alarm_cnt SHALL increment on each transition into ALARM, saturate at 15, clear only by reset.
REQ-028 All outputs SHALL be registered; state/alarm reflect the new state one cycle after the triggering input is sampled.
REQ-029 arm held high SHALL NOT re-arm after a disarm until arm is observed in DISARMED (one cycle minimum in DISARMED).
REQ-030 Counter SHALL never wrap: loads occur only on state entry, decrement only while nonzero.

Reset
REQ-031 rst_n low SHALL asynchronously set state=DISARMED, alarm=0, tripped=0, alarm_cnt=0, counter=0.
REQ-032 Reset mid-ALARM or mid-delay SHALL abort immediately; after release the block waits in DISARMED for arm.
REQ-033 First active edge after rst_n deasserts SHALL evaluate inputs normally.

Verification (defaults, NUM_ZONES=4)
REQ-034 Arm pulse, zones quiet -> state EXIT for 8 cycles, ARMED on 9th cycle after arm sampled; tripped=0.
REQ-035 ARMED, zone_en=4'hF, zone_delayed=4'h1, zone_in=4'h1 one cycle -> ENTRY 8 cycles, ALARM 16 cycles with alarm=1, then LOCKOUT; tripped=4'h1, alarm_cnt=1.
REQ-036 ENTRY in progress, zone_in=4'h4 (instant) -> ALARM next cycle, tripped=4'h5.
REQ-037 ARMED, zone_en=4'h7, zone_in=4'h8 -> remains ARMED, tripped=0; zone_in during EXIT -> ignored.
REQ-038 ALARM, arm=1 and disarm=1 same cycle -> DISARMED next cycle, alarm=0; tripped retained until next arm.
REQ-039 17 alarm cycles via repeated arm/trip/disarm -> alarm_cnt stays 15; rst_n pulse mid-ALARM -> all outputs 0 immediately.
